// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and stage-control outputs of the bittyCore pipeline sequencer.
// The perf counter signals exist only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if;
  logic        id_load_use;
  logic        ex_mc_start;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic [5:0]  stall;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        new_pc_valid;
  logic [31:0] new_pc;
  logic        mc_busy;
  logic        mc_done;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  // master: the controller; slave: the pipeline datapath it steers
  modport master (
    input  id_load_use, ex_mc_start, ex_branch_taken, ex_branch_target,
    output stall, flush_if_id, flush_id_ex, new_pc_valid, new_pc, mc_busy, mc_done
`ifdef PIPE_CTRL_PERF_EN
    , output perf_stall_cnt, perf_flush_cnt
`endif
  );

  modport slave (
    output id_load_use, ex_mc_start, ex_branch_taken, ex_branch_target,
    input  stall, flush_if_id, flush_id_ex, new_pc_valid, new_pc, mc_busy, mc_done
`ifdef PIPE_CTRL_PERF_EN
    , input perf_stall_cnt, perf_flush_cnt
`endif
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: arbitrates branch > multi-cycle > load-use hazards into per-stage
// hold/bubble controls. Optional PIPE_CTRL_PERF_EN adds stall/flush cycle counters.
module pipe_ctrl #(
  parameter int unsigned MC_CYCLES = 32,
  parameter int unsigned CNT_W     = 6
) (
  input  logic          clk,
  input  logic          rst,
  pipe_ctrl_if.master   bus
);

  typedef enum logic [1:0] {StIdle, StMcBusy, StMcDone} state_e;

  localparam logic [CNT_W-1:0] CntInit = CNT_W'(MC_CYCLES - 1);
  localparam logic [5:0] StallMc = 6'b001111;
  localparam logic [5:0] StallLu = 6'b000011;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    bus.stall        = '0;
    bus.flush_if_id  = 1'b0;
    bus.flush_id_ex  = 1'b0;
    bus.new_pc_valid = 1'b0;
    bus.new_pc       = '0;
    bus.mc_busy      = 1'b0;
    bus.mc_done      = 1'b0;
    unique case (state_q)
      StIdle, StMcDone: begin
        if (state_q == StMcDone) begin
          bus.mc_done = 1'b1;
          state_d     = StIdle;
        end
        if (bus.ex_branch_taken) begin
          bus.flush_if_id  = 1'b1;
          bus.flush_id_ex  = 1'b1;
          bus.new_pc_valid = 1'b1;
          bus.new_pc       = bus.ex_branch_target;
        end else if (bus.ex_mc_start && state_q == StIdle) begin
          state_d   = StMcBusy;
          cnt_d     = CntInit;
          bus.stall = StallMc;
        end else if (bus.id_load_use) begin
          bus.stall       = StallLu;
          bus.flush_id_ex = 1'b1;
        end
      end
      StMcBusy: begin
        bus.stall   = StallMc;
        bus.mc_busy = 1'b1;
        // Leaving at cnt<=1 gives MC_CYCLES stalls in total including the start cycle,
        // while MC_CYCLES=1 still spends its single busy cycle at cnt=0.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = StMcDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (bus.stall != '0) perf_stall_q <= perf_stall_q + 32'd1;
      if (bus.flush_if_id) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = perf_stall_q;
  assign bus.perf_flush_cnt = perf_flush_q;
`endif

endmodule
